// File: rtl/edge_pkg.sv
// Shared types and helpers for the Sobel edge-magnitude pipeline.
package edge_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    function automatic int unsigned grad_w(input int unsigned data_w);
        return data_w + 32'd3;
    endfunction

    localparam int unsigned GRAD_W = grad_w(DATA_W_DEF);

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } pos_flags_t;

    // Clamp an unsigned value to the largest value representable in out_w bits.
    function automatic logic [31:0] saturate_u(input logic [31:0] val, input int unsigned out_w);
        logic [31:0] max_v;
        max_v = (32'd1 << out_w) - 32'd1;
        if (val > max_v) begin
            return max_v;
        end else begin
            return val;
        end
    endfunction

endpackage

// File: rtl/edge_win_pos_cnt.sv
// Column/row position counter over the output window grid; emits sof/eol/eof
// for the window currently presented on i_valid.
module edge_win_pos_cnt
    import edge_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    output pos_flags_t o_flags
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             w_eol;
    logic             w_last_row;

    assign w_eol      = (r_col == COL_W'(IMG_W - 3));
    assign w_last_row = (r_row == ROW_W'(IMG_H - 3));

    // Advance raster position on each accepted window, wrapping at line and frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_valid) begin
            if (w_eol) begin
                r_col <= '0;
                if (w_last_row) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + ROW_W'(1);
                end
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Flags describe the position of the window being accepted this cycle.
    always_comb begin
        o_flags     = '0;
        o_flags.sof = (r_col == COL_W'(0)) && (r_row == ROW_W'(0));
        o_flags.eol = w_eol;
        o_flags.eof = w_eol && w_last_row;
    end

endmodule

// File: rtl/sobel_mag_3x3.sv
// Sobel |Gx|+|Gy| magnitude with scaling, saturation and thresholding over a
// 3x3 window stream; fixed 3-cycle latency with position flags carried along.
module sobel_mag_3x3
    import edge_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int MAG_SHIFT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] w00,
    input  logic [DATA_W-1:0] w01,
    input  logic [DATA_W-1:0] w02,
    input  logic [DATA_W-1:0] w10,
    input  logic [DATA_W-1:0] w11,
    input  logic [DATA_W-1:0] w12,
    input  logic [DATA_W-1:0] w20,
    input  logic [DATA_W-1:0] w21,
    input  logic [DATA_W-1:0] w22,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] thresh,
    output logic [DATA_W-1:0] mag_out,
    output logic              edge_out,
    output logic              valid_out,
    output logic              sof_out,
    output logic              eol_out,
    output logic              eof_out
);

    localparam int SUM_W = DATA_W + 2;
    localparam int G_W   = int'(grad_w(DATA_W));

    pos_flags_t        w_flags;
    logic [SUM_W-1:0]  w_r, w_l, w_b, w_t;
    logic [G_W-1:0]    w_gx, w_gy;
    logic [SUM_W-1:0]  w_ax, w_ay;
    logic [G_W-1:0]    w_s;
    logic [DATA_W-1:0] w_mag;

    logic              r_v1, r_v2;
    pos_flags_t        r_f1, r_f2;
    logic [SUM_W-1:0]  r_r, r_l, r_b, r_t;
    logic [SUM_W-1:0]  r_ax, r_ay;

    edge_win_pos_cnt #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_pos (
        .clk     (clk),
        .rst     (rst),
        .i_valid (valid_in),
        .o_flags (w_flags)
    );

    // Weighted column (R/L) and row (B/T) sums; the centre tap is doubled by a shift.
    always_comb begin
        w_r = {2'b00, w02} + {1'b0, w12, 1'b0} + {2'b00, w22};
        w_l = {2'b00, w00} + {1'b0, w10, 1'b0} + {2'b00, w20};
        w_b = {2'b00, w20} + {1'b0, w21, 1'b0} + {2'b00, w22};
        w_t = {2'b00, w00} + {1'b0, w01, 1'b0} + {2'b00, w02};
    end

    // Two's-complement differences; magnitudes never exceed 4*(2^DATA_W-1), so SUM_W bits suffice.
    always_comb begin
        w_gx = {1'b0, r_r} - {1'b0, r_l};
        w_gy = {1'b0, r_b} - {1'b0, r_t};
        w_ax = w_gx[G_W-1] ? SUM_W'(G_W'(0) - w_gx) : SUM_W'(w_gx);
        w_ay = w_gy[G_W-1] ? SUM_W'(G_W'(0) - w_gy) : SUM_W'(w_gy);
    end

    // Scale and clamp; the threshold compares against the clamped value.
    always_comb begin
        w_s   = (G_W'(r_ax) + G_W'(r_ay)) >> MAG_SHIFT;
        w_mag = DATA_W'(saturate_u(32'(w_s), DATA_W));
    end

    // Stage 1: capture sums and position flags of the incoming window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_f1 <= '0;
            r_r  <= '0;
            r_l  <= '0;
            r_b  <= '0;
            r_t  <= '0;
        end else begin
            r_v1 <= valid_in;
            if (valid_in) begin
                r_f1 <= w_flags;
                r_r  <= w_r;
                r_l  <= w_l;
                r_b  <= w_b;
                r_t  <= w_t;
            end
        end
    end

    // Stage 2: absolute gradients.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2 <= 1'b0;
            r_f2 <= '0;
            r_ax <= '0;
            r_ay <= '0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_f2 <= r_f1;
                r_ax <= w_ax;
                r_ay <= w_ay;
            end
        end
    end

    // Stage 3: registered outputs; data and flags hold between beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            mag_out   <= '0;
            edge_out  <= 1'b0;
            sof_out   <= 1'b0;
            eol_out   <= 1'b0;
            eof_out   <= 1'b0;
        end else begin
            valid_out <= r_v2;
            if (r_v2) begin
                mag_out  <= w_mag;
                edge_out <= (w_mag >= thresh);
                sof_out  <= r_f2.sof;
                eol_out  <= r_f2.eol;
                eof_out  <= r_f2.eof;
            end
        end
    end

endmodule

// File: tb/tb_sobel_mag_3x3.sv
// Bench for sobel_mag_3x3: two instances (MAG_SHIFT 0 and 2) on an 8x5 image.
module tb_sobel_mag_3x3;

    localparam int TW = 8;
    localparam int TH = 5;
    localparam int NW = TW - 2;
    localparam int NB = (TW - 2) * (TH - 2);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [71:0] r_win = '0;
    logic        valid_in = 1'b0;
    logic [7:0]  thresh = 8'd0;

    logic [7:0]  m0, m2;
    logic        e0, v0, s0, l0, f0;
    logic        e2, v2, s2, l2, f2;

    always #5 clk = ~clk;

    sobel_mag_3x3 #(.DATA_W(8), .IMG_W(TW), .IMG_H(TH), .MAG_SHIFT(0)) dut0 (
        .clk(clk), .rst(rst),
        .w00(r_win[7:0]),   .w01(r_win[15:8]),  .w02(r_win[23:16]),
        .w10(r_win[31:24]), .w11(r_win[39:32]), .w12(r_win[47:40]),
        .w20(r_win[55:48]), .w21(r_win[63:56]), .w22(r_win[71:64]),
        .valid_in(valid_in), .thresh(thresh),
        .mag_out(m0), .edge_out(e0), .valid_out(v0),
        .sof_out(s0), .eol_out(l0), .eof_out(f0)
    );

    sobel_mag_3x3 #(.DATA_W(8), .IMG_W(TW), .IMG_H(TH), .MAG_SHIFT(2)) dut2 (
        .clk(clk), .rst(rst),
        .w00(r_win[7:0]),   .w01(r_win[15:8]),  .w02(r_win[23:16]),
        .w10(r_win[31:24]), .w11(r_win[39:32]), .w12(r_win[47:40]),
        .w20(r_win[55:48]), .w21(r_win[63:56]), .w22(r_win[71:64]),
        .valid_in(valid_in), .thresh(thresh),
        .mag_out(m2), .edge_out(e2), .valid_out(v2),
        .sof_out(s2), .eol_out(l2), .eof_out(f2)
    );

    typedef struct {
        bit          v;
        logic [71:0] win;
        int          bidx;
        int          k4;
    } hbeat_t;

    typedef struct {
        logic [71:0] win;
        logic [7:0]  th;
        int          m0;
        bit          e0;
        int          m2;
        bit          e2;
    } vec_t;

    hbeat_t hist [3];
    vec_t   tbl  [8];
    int     n_chk  = 0;
    int     n_fail = 0;
    int     bidx   = 0;
    int     n_in   = 0;
    int     n_out  = 0;

    function automatic logic [71:0] mk(int a00, int a01, int a02, int a10, int a11,
                                       int a12, int a20, int a21, int a22);
        return {8'(a22), 8'(a21), 8'(a20), 8'(a12), 8'(a11), 8'(a10), 8'(a02), 8'(a01), 8'(a00)};
    endfunction

    function automatic logic [71:0] rnd_win();
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[8*k +: 8] = 8'($urandom_range(0, 255));
        return w;
    endfunction

    function automatic int gmag(logic [71:0] win, int sh);
        int p [9];
        int gx, gy, s;
        for (int k = 0; k < 9; k++) p[k] = int'(win[8*k +: 8]);
        gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        s = (gx + gy) >> sh;
        return (s > 255) ? 255 : s;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_out();
        hbeat_t h;
        int     pos, em0, em2;
        h = hist[2];
        if (v0) n_out++;
        if (h.v) begin
            pos = h.bidx % NB;
            em0 = gmag(h.win, 0);
            em2 = gmag(h.win, 2);
            chk("valid_out0", int'(v0), 1);
            chk("valid_out2", int'(v2), 1);
            chk("mag0", int'(m0), em0);
            chk("mag2", int'(m2), em2);
            chk("edge0", int'(e0), int'(em0 >= int'(thresh)));
            chk("edge2", int'(e2), int'(em2 >= int'(thresh)));
            chk("sof0", int'(s0), int'(pos == 0));
            chk("eol0", int'(l0), int'((pos % NW) == NW - 1));
            chk("eof0", int'(f0), int'(pos == NB - 1));
            chk("sof2", int'(s2), int'(pos == 0));
            if (h.k4 != 0) begin
                chk("hand_sof", int'(s0), int'(h.k4 == 1 || h.k4 == 19));
                chk("hand_eol", int'(l0), int'(h.k4 == 6 || h.k4 == 12 || h.k4 == 18));
                chk("hand_eof", int'(f0), int'(h.k4 == 18));
            end
        end else begin
            chk("idle_valid0", int'(v0), 0);
            chk("idle_valid2", int'(v2), 0);
        end
    endtask

    task automatic cyc(bit v, logic [71:0] win, int k4);
        @(negedge clk);
        check_out();
        hist[2]      = hist[1];
        hist[1]      = hist[0];
        hist[0].v    = v;
        hist[0].win  = win;
        hist[0].bidx = bidx;
        hist[0].k4   = k4;
        if (v) begin
            bidx++;
            n_in++;
        end
        valid_in = v;
        r_win    = win;
    endtask

    task automatic do_reset(bit with_beat, logic [71:0] win);
        @(negedge clk);
        rst      = 1'b1;
        valid_in = with_beat;
        r_win    = win;
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        chk("rst_valid0", int'(v0), 0);
        chk("rst_valid2", int'(v2), 0);
        chk("rst_mag0", int'(m0), 0);
        chk("rst_edge0", int'(e0), 0);
        chk("rst_flags0", int'({s0, l0, f0}), 0);
        chk("rst_mag2", int'(m2), 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) hist[i] = '{v: 1'b0, win: 72'd0, bidx: 0, k4: 0};
        bidx  = 0;
        n_in  = 0;
        n_out = 0;
    endtask

    initial begin
        tbl[0] = '{mk(100,100,100,100,100,100,100,100,100), 8'd1,   0,   1'b0, 0,   1'b0};
        tbl[1] = '{mk(0,0,255,0,0,255,0,0,255),             8'd200, 255, 1'b1, 255, 1'b1};
        tbl[2] = '{mk(255,0,0,0,0,0,0,0,0),                 8'd128, 255, 1'b1, 127, 1'b0};
        tbl[3] = '{mk(0,0,0,0,0,0,255,255,255),             8'd255, 255, 1'b1, 255, 1'b1};
        tbl[4] = '{mk(0,0,10,0,0,0,0,0,0),                  8'd20,  20,  1'b1, 5,   1'b0};
        tbl[5] = '{mk(0,0,0,0,0,50,0,0,0),                  8'd26,  100, 1'b1, 25,  1'b0};
        tbl[6] = '{mk(0,0,0,0,0,0,0,3,0),                   8'd6,   6,   1'b1, 1,   1'b0};
        tbl[7] = '{mk(10,20,30,40,50,60,70,80,90),          8'd80,  255, 1'b1, 80,  1'b1};

        do_reset(1'b0, 72'd0);

        // Directed vectors: one beat, then watch the 3-cycle latency and compare to hand values.
        for (int i = 0; i < 8; i++) begin
            thresh = tbl[i].th;
            cyc(1'b1, tbl[i].win, 0);
            for (int j = 0; j < 3; j++) cyc(1'b0, 72'd0, 0);
            chk("tbl_mag0",  int'(m0), tbl[i].m0);
            chk("tbl_edge0", int'(e0), int'(tbl[i].e0));
            chk("tbl_mag2",  int'(m2), tbl[i].m2);
            chk("tbl_edge2", int'(e2), int'(tbl[i].e2));
        end

        // One full frame back-to-back plus the first beat of the next frame.
        thresh = 8'd100;
        do_reset(1'b0, 72'd0);
        for (int k = 1; k <= 19; k++) cyc(1'b1, rnd_win(), k);
        for (int j = 0; j < 3; j++) cyc(1'b0, 72'd0, 0);
        chk("frame_out_count", n_out, n_in);

        // Random gaps on valid_in.
        do_reset(1'b0, 72'd0);
        for (int c = 0; c < 120; c++) cyc(($urandom_range(0, 2) != 0), rnd_win(), 0);
        for (int j = 0; j < 4; j++) cyc(1'b0, 72'd0, 0);
        chk("gap_out_count", n_out, n_in);

        // Reset on beat 7 with beats in flight, then one fresh beat must be sof.
        do_reset(1'b0, 72'd0);
        for (int k = 1; k <= 6; k++) cyc(1'b1, rnd_win(), 0);
        do_reset(1'b1, rnd_win());
        for (int j = 0; j < 4; j++) cyc(1'b0, 72'd0, 0);
        chk("post_rst_no_out", n_out, 0);
        cyc(1'b1, mk(0,0,255,0,0,255,0,0,255), 1);
        for (int j = 0; j < 3; j++) cyc(1'b0, 72'd0, 0);
        chk("post_rst_sof", int'(s0), 1);
        chk("post_rst_count", n_out, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
